// File: rtl/axi_req_master.sv
// axi_req_master
// Single-outstanding AXI4 manager: converts one valid/ready load/store request
// into one single-beat AXI transaction and returns the completion on a
// valid/ready response port.
//
// Handshake rule used on every channel here: a transfer happens on a rising
// clock edge where valid and ready are both high; once valid is raised it stays
// high with a stable payload until that transfer.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   req_*               request channel (valid/ready, we, addr, size, wdata, wstrb)
//   resp_*              completion channel (valid/ready, rdata, err)
//   busy_o              high whenever the FSM is not IDLE
//   dbg_state_o         current FSM state (debug visibility)
//   axi_mosi_o          AXI manager -> subordinate signals
//   axi_miso_i          AXI subordinate -> manager signals

package amba_axi_pkg;
  localparam int AXI_ID_W = 4;

  typedef logic [2:0] axi_size_t;
  localparam axi_size_t AXI_SIZE_BYTE = 3'd0;
  localparam axi_size_t AXI_SIZE_HALF = 3'd1;
  localparam axi_size_t AXI_SIZE_WORD = 3'd2;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
  localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic                awvalid;
    logic [AXI_ID_W-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    axi_size_t           awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awuser;
    logic                wvalid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wuser;
    logic                bready;
    logic                arvalid;
    logic [AXI_ID_W-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    axi_size_t           arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                aruser;
    logic                rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                awready;
    logic                wready;
    logic                bvalid;
    logic [AXI_ID_W-1:0] bid;
    axi_resp_t           bresp;
    logic                arready;
    logic                rvalid;
    logic [AXI_ID_W-1:0] rid;
    logic [31:0]         rdata;
    axi_resp_t           rresp;
    logic                rlast;
  } s_axi_miso_t;
endpackage

module axi_req_master
  import amba_axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] AXI_ID = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  axi_size_t   req_size_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic [2:0]  dbg_state_o,
  output s_axi_mosi_t axi_mosi_o,
  input  s_axi_miso_t axi_miso_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic        aw_valid_q, aw_valid_d;
  logic        w_valid_q, w_valid_d;
  logic        ar_valid_q, ar_valid_d;
  logic        b_ready_q, b_ready_d;
  logic        r_ready_q, r_ready_d;
  logic [31:0] addr_q, addr_d;
  axi_size_t   size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // A channel is done once its valid has dropped, or in the cycle its
  // handshake fires; this lets WR_REQ leave in the cycle of the last one.
  logic aw_done, w_done;
  assign aw_done = !aw_valid_q || axi_miso_i.awready;
  assign w_done  = !w_valid_q  || axi_miso_i.wready;

  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    ar_valid_d = ar_valid_q;
    b_ready_d  = b_ready_q;
    r_ready_d  = r_ready_q;
    addr_d     = addr_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d  = req_addr_i;
          size_d  = req_size_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          rdata_d = '0;
          err_d   = 1'b0;
          if (req_we_i) begin
            state_d    = WR_REQ;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = RD_REQ;
            ar_valid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_valid_q && axi_miso_i.awready) aw_valid_d = 1'b0;
        if (w_valid_q && axi_miso_i.wready)   w_valid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d   = WR_RESP;
          b_ready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_ready_q && axi_miso_i.bvalid) begin
          state_d   = DONE;
          b_ready_d = 1'b0;
          rdata_d   = '0;
          err_d     = (axi_miso_i.bresp == AXI_RESP_SLVERR) ||
                      (axi_miso_i.bresp == AXI_RESP_DECERR) ||
                      (axi_miso_i.bid != AXI_ID);
        end
      end
      RD_REQ: begin
        if (ar_valid_q && axi_miso_i.arready) begin
          state_d    = RD_RESP;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_ready_q && axi_miso_i.rvalid) begin
          state_d   = DONE;
          r_ready_d = 1'b0;
          rdata_d   = axi_miso_i.rdata;
          err_d     = (axi_miso_i.rresp == AXI_RESP_SLVERR) ||
                      (axi_miso_i.rresp == AXI_RESP_DECERR) ||
                      (axi_miso_i.rid != AXI_ID) ||
                      !axi_miso_i.rlast;
        end
      end
      DONE: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        aw_valid_d = 1'b0;
        w_valid_d  = 1'b0;
        ar_valid_d = 1'b0;
        b_ready_d  = 1'b0;
        r_ready_d  = 1'b0;
      end
    endcase

    // Status outputs are registered alongside the state so they read 0 in reset.
    req_ready_d  = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    resp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      b_ready_q    <= 1'b0;
      r_ready_q    <= 1'b0;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      ar_valid_q   <= ar_valid_d;
      b_ready_q    <= b_ready_d;
      r_ready_q    <= r_ready_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign busy_o       = busy_q;
  assign dbg_state_o  = state_q;

  // Single-beat INCR transactions; unused attribute fields stay 0.
  always_comb begin
    axi_mosi_o         = '0;
    axi_mosi_o.awvalid = aw_valid_q;
    axi_mosi_o.awid    = AXI_ID;
    axi_mosi_o.awaddr  = addr_q;
    axi_mosi_o.awsize  = size_q;
    axi_mosi_o.awburst = AXI_BURST_INCR;
    axi_mosi_o.wvalid  = w_valid_q;
    axi_mosi_o.wdata   = wdata_q;
    axi_mosi_o.wstrb   = wstrb_q;
    axi_mosi_o.wlast   = w_valid_q;
    axi_mosi_o.bready  = b_ready_q;
    axi_mosi_o.arvalid = ar_valid_q;
    axi_mosi_o.arid    = AXI_ID;
    axi_mosi_o.araddr  = addr_q;
    axi_mosi_o.arsize  = size_q;
    axi_mosi_o.arburst = AXI_BURST_INCR;
    axi_mosi_o.rready  = r_ready_q;
  end

endmodule

// File: tb/tb_axi_req_master.sv
// Bench for axi_req_master: directed cases followed by randomized traffic
// against a latency-configurable AXI subordinate with a small memory.
module tb_axi_req_master;
  import amba_axi_pkg::*;

  localparam logic [AXI_ID_W-1:0] TB_ID = 4'h3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  axi_size_t   req_size = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready_o, resp_valid_o, resp_err_o, busy_o;
  logic [31:0] resp_rdata_o;
  logic [2:0]  dbg_state_o;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  axi_req_master #(.AXI_ID(TB_ID)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o),
    .axi_mosi_o(axi_mosi), .axi_miso_i(axi_miso)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];   // {err, rdata}

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bytes [off, off+2^size) of a word; everything else zero.
  function automatic logic [31:0] lane_sel(input logic [31:0] w, input logic [1:0] off,
                                           input axi_size_t size);
    logic [31:0] r;
    int n;
    r = '0;
    n = 1 << size;
    for (int b = 0; b < 4; b++)
      if (b >= int'(off) && b < int'(off) + n) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // ---------------- subordinate configuration / state ----------------
  int        cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0;
  axi_resp_t cfg_resp = AXI_RESP_OKAY;
  logic [AXI_ID_W-1:0] cfg_id = TB_ID;
  logic      cfg_rlast = 1'b1;

  logic [31:0] cur_addr = '0, cur_wdata = '0;
  axi_size_t   cur_size = '0;
  logic [3:0]  cur_wstrb = '0;

  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];
  int aw_hi, w_hi, ar_hi, aw_hs_cyc, w_hs_cyc;

  // Subordinate: samples handshakes at the clock edge, drives readys and
  // responses just after it. B/R come one cycle after the request handshake.
  initial begin : subordinate
    s_axi_mosi_t m, m_p;
    s_axi_miso_t s;
    bit aw_got, w_got, b_pend, r_pend, aw_st, w_st, ar_st;
    int aw_cnt, w_cnt, ar_cnt;
    logic [31:0] aw_a, w_d, r_d;
    logic [3:0]  w_s;
    axi_miso = '0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_st = 0; w_st = 0; ar_st = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_a = '0; w_d = '0; w_s = '0; r_d = '0; m_p = '0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_st = 0; w_st = 0; ar_st = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        #1 axi_miso = '0;
        continue;
      end
      m = axi_mosi;
      s = axi_miso;
      // payload must hold while a valid waits for ready
      if (aw_st) check("aw_hold", {m.awvalid, m.awaddr, m.awsize}, {1'b1, m_p.awaddr, m_p.awsize});
      if (w_st)  check("w_hold", {m.wvalid, m.wdata, m.wstrb}, {1'b1, m_p.wdata, m_p.wstrb});
      if (ar_st) check("ar_hold", {m.arvalid, m.araddr, m.arsize}, {1'b1, m_p.araddr, m_p.arsize});
      aw_st = m.awvalid && !s.awready;
      w_st  = m.wvalid && !s.wready;
      ar_st = m.arvalid && !s.arready;
      m_p   = m;
      if (m.awvalid) aw_hi++;
      if (m.wvalid)  w_hi++;
      if (m.arvalid) ar_hi++;
      if (m.bready) check("bready_after_aw_w", {aw_got, w_got}, 2'b11);
      if (m.awvalid && !s.awready) aw_cnt++;
      if (m.wvalid && !s.wready)   w_cnt++;
      if (m.arvalid && !s.arready) ar_cnt++;

      if (m.awvalid && s.awready) begin
        aw_got = 1; aw_cnt = 0; aw_a = m.awaddr; aw_hs_cyc = cyc;
        check("awaddr", m.awaddr, cur_addr);
        check("aw_fixed", {m.awid, m.awlen, m.awsize, m.awburst}, {TB_ID, 8'd0, cur_size, 2'b01});
        check("aw_attr_zero", {m.awlock, m.awcache, m.awprot, m.awqos, m.awregion, m.awuser}, 0);
      end
      if (m.wvalid && s.wready) begin
        w_got = 1; w_cnt = 0; w_d = m.wdata; w_s = m.wstrb; w_hs_cyc = cyc;
        check("w_payload", {m.wdata, m.wstrb, m.wlast}, {cur_wdata, cur_wstrb, 1'b1});
      end
      if (m.bready && s.bvalid) begin
        aw_got = 0; w_got = 0; b_pend = 0;
      end else if (aw_got && w_got && !b_pend) begin
        b_pend = 1;
        for (int b = 0; b < 4; b++)
          if (w_s[b]) slv_mem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
      end
      if (m.arvalid && s.arready) begin
        ar_cnt = 0; r_pend = 1;
        r_d = lane_sel(slv_mem[m.araddr[5:2]], m.araddr[1:0], m.arsize);
        check("araddr", m.araddr, cur_addr);
        check("ar_fixed", {m.arid, m.arlen, m.arsize, m.arburst}, {TB_ID, 8'd0, cur_size, 2'b01});
        check("ar_attr_zero", {m.arlock, m.arcache, m.arprot, m.arqos, m.arregion, m.aruser}, 0);
      end
      if (m.rready && s.rvalid) r_pend = 0;

      #1;
      axi_miso.awready = axi_mosi.awvalid && (aw_cnt >= cfg_aw_lat);
      axi_miso.wready  = axi_mosi.wvalid  && (w_cnt  >= cfg_w_lat);
      axi_miso.arready = axi_mosi.arvalid && (ar_cnt >= cfg_ar_lat);
      axi_miso.bvalid  = b_pend;
      axi_miso.bresp   = cfg_resp;
      axi_miso.bid     = cfg_id;
      axi_miso.rvalid  = r_pend;
      axi_miso.rdata   = r_d;
      axi_miso.rresp   = cfg_resp;
      axi_miso.rid     = cfg_id;
      axi_miso.rlast   = cfg_rlast;
    end
  end

  // ---------------- reference model ----------------
  // Completion = {err, rdata}; memory is updated with strobed bytes on writes.
  function automatic logic [32:0] model_txn(input bit we, input logic [31:0] addr,
      input axi_size_t size, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic err;
    logic [31:0] rd;
    err = (cfg_resp >= 2) || (cfg_id != TB_ID) || (!we && !cfg_rlast);
    rd = we ? 32'h0 : lane_sel(ref_mem[addr[5:2]], addr[1:0], size);
    if (we)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
    return {err, rd};
  endfunction

  // ---------------- driver ----------------
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_txn(input bit we, input logic [31:0] addr, input axi_size_t size,
      input logic [31:0] wdata, input logic [3:0] wstrb, input int bp, input bit chk_lat);
    logic [32:0] exp, got;
    int acc_cyc, t;
    exp_q.push_back(model_txn(we, addr, size, wdata, wstrb));
    cur_addr = addr; cur_size = size; cur_wdata = wdata; cur_wstrb = wstrb;
    aw_hi = 0; w_hi = 0; ar_hi = 0; aw_hs_cyc = -1; w_hs_cyc = -2;
    req_we = we; req_addr = addr; req_size = size; req_wdata = wdata; req_wstrb = wstrb;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    check("accept_timeout", t < 50, 1);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", {busy_o, req_ready_o}, 2'b10);
    check("valids_n_plus_1", {axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.arvalid},
          we ? 3'b110 : 3'b001);
    t = 0;
    while (!resp_valid_o && t < 200) begin @(negedge clk); t++; end
    check("resp_timeout", t < 200, 1);
    last_lat = cyc - acc_cyc;
    if (chk_lat) check("resp_latency", last_lat, 3);
    got = {resp_err_o, resp_rdata_o};
    exp = exp_q.pop_front();
    check("resp_data", got, exp);
    last_rdata = resp_rdata_o;
    last_err   = resp_err_o;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_hold", {resp_valid_o, req_ready_o, got}, {1'b1, 1'b0, exp});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done", {resp_valid_o, busy_o, req_ready_o}, 3'b001);
  endtask

  task automatic set_cfg(input int awl, input int wl, input int arl, input axi_resp_t r,
                         input logic [AXI_ID_W-1:0] id, input logic rl);
    cfg_aw_lat = awl; cfg_w_lat = wl; cfg_ar_lat = arl;
    cfg_resp = r; cfg_id = id; cfg_rlast = rl;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int t;
    for (int i = 0; i < 16; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

    // reset
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready_o, resp_valid_o, resp_err_o, busy_o, resp_rdata_o}, 0);
    check("reset_axi", {axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.bready,
                        axi_mosi.arvalid, axi_mosi.rready}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", {req_ready_o, busy_o}, 2'b10);

    // word write, always-ready subordinate
    set_cfg(0, 0, 0, AXI_RESP_OKAY, TB_ID, 1'b1);
    do_txn(1, 32'h100, AXI_SIZE_WORD, 32'hDEADBEEF, 4'hF, 0, 1);
    check("wr_resp", {last_err, last_rdata}, 33'h0);
    check("aw_w_same_cycle", aw_hs_cyc, w_hs_cyc);
    check("aw_one_cycle", aw_hi, 1);

    // read-back and byte read
    do_txn(0, 32'h100, AXI_SIZE_WORD, 32'h0, 4'h0, 0, 1);
    check("rd_word", {last_err, last_rdata}, {1'b0, 32'hDEADBEEF});
    check("ar_one_cycle", ar_hi, 1);
    do_txn(0, 32'h101, AXI_SIZE_BYTE, 32'h0, 4'h0, 0, 1);
    check("rd_byte", {last_err, last_rdata}, {1'b0, 32'h0000BE00});

    // skewed write handshakes
    set_cfg(3, 0, 0, AXI_RESP_OKAY, TB_ID, 1'b1);
    do_txn(1, 32'h104, AXI_SIZE_WORD, 32'h12345678, 4'hF, 0, 0);
    check("skew_aw_cycles", aw_hi, 4);
    check("skew_w_cycles", w_hi, 1);
    check("skew_latency", last_lat, 6);

    // error paths
    set_cfg(0, 0, 0, AXI_RESP_SLVERR, TB_ID, 1'b1);
    do_txn(1, 32'h108, AXI_SIZE_WORD, 32'hA5A5A5A5, 4'hF, 0, 1);
    check("bresp_slverr", last_err, 1);
    set_cfg(0, 0, 0, AXI_RESP_OKAY, TB_ID + 1, 1'b1);
    do_txn(0, 32'h104, AXI_SIZE_WORD, 32'h0, 4'h0, 0, 1);
    check("rid_mismatch", {last_err, last_rdata}, {1'b1, 32'h12345678});
    set_cfg(0, 0, 0, AXI_RESP_EXOKAY, TB_ID, 1'b1);
    do_txn(0, 32'h108, AXI_SIZE_WORD, 32'h0, 4'h0, 0, 1);
    check("rresp_exokay", {last_err, last_rdata}, {1'b0, 32'hA5A5A5A5});
    set_cfg(0, 0, 0, AXI_RESP_OKAY, TB_ID, 1'b0);
    do_txn(0, 32'h100, AXI_SIZE_HALF, 32'h0, 4'h0, 0, 1);
    check("rlast_low", {last_err, last_rdata}, {1'b1, 32'h0000BEEF});

    // completion backpressure, then next request straight after
    set_cfg(0, 0, 0, AXI_RESP_OKAY, TB_ID, 1'b1);
    do_txn(0, 32'h102, AXI_SIZE_HALF, 32'h0, 4'h0, 5, 1);
    check("bp_read", last_rdata, 32'hDEAD0000);
    do_txn(1, 32'h10C, AXI_SIZE_WORD, 32'hCAFEF00D, 4'h3, 0, 1);

    // reset while arvalid waits for arready
    set_cfg(0, 0, 1000, AXI_RESP_OKAY, TB_ID, 1'b1);
    cur_addr = 32'h10C; cur_size = AXI_SIZE_WORD;
    req_we = 1'b0; req_addr = 32'h10C; req_size = AXI_SIZE_WORD; req_valid = 1'b1;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk); t++; end
    check("rst_accept_timeout", t < 50, 1);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ar_waiting", {axi_mosi.arvalid, busy_o}, 2'b11);
    #2 rst = 1'b0;
    #1 check("reset_mid_txn", {axi_mosi.arvalid, busy_o, req_ready_o, resp_valid_o}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cfg_ar_lat = 0;
    @(negedge clk);
    check("idle_after_reset", {req_ready_o, resp_valid_o, busy_o}, 3'b100);
    repeat (3) @(negedge clk);
    check("no_stale_resp", resp_valid_o, 0);
    do_txn(0, 32'h10C, AXI_SIZE_WORD, 32'h0, 4'h0, 0, 1);
    check("fresh_read", {last_err, last_rdata}, {1'b0, 32'h0000F00D});

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      bit we;
      axi_size_t sz;
      logic [1:0] off;
      logic [31:0] a;
      int awl, wl, arl;
      we = $urandom_range(0, 1);
      sz = axi_size_t'($urandom_range(0, 2));
      off = (sz == AXI_SIZE_WORD) ? 2'd0 :
            (sz == AXI_SIZE_HALF) ? 2'($urandom_range(0, 1) * 2) : 2'($urandom_range(0, 3));
      a = 32'h100 + 32'($urandom_range(0, 15) * 4) + {30'd0, off};
      awl = $urandom_range(0, 2); wl = $urandom_range(0, 2); arl = $urandom_range(0, 2);
      set_cfg(awl, wl, arl, axi_resp_t'($urandom_range(0, 3)),
              ($urandom_range(0, 4) == 0) ? TB_ID + 1 : TB_ID,
              ($urandom_range(0, 5) != 0));
      do_txn(we, a, sz, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
             we ? (awl == 0 && wl == 0) : (arl == 0));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_req_master.md
# axi_req_master

Single-outstanding AXI4 manager that turns a simple valid/ready load/store request into one single-beat AXI transaction and returns the completion on a valid/ready response port. It sits between a core-side requester (LSU, DMA engine or test sequencer) and any AXI subordinate on the interconnect. It drives `s_axi_mosi_t` and consumes `s_axi_miso_t` from `amba_axi_pkg`.

## Interface
- `AXI_ID`, default 0: value driven on `awid`/`arid`; also the expected `bid`/`rid`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  32  byte address; passed unmodified to `awaddr`/`araddr`.
- `req_size_i`  in  `axi_size_t`  transfer size (byte/half/word).
- `req_wdata_i`  in  32  write data, already placed on the correct byte lanes.
- `req_wstrb_i`  in  4  write strobes.
- `resp_valid_o`  out  1  completion valid.
- `resp_ready_i`  in  1  completion consumed.
- `resp_rdata_o`  out  32  read data as returned on the bus; 0 for writes.
- `resp_err_o`  out  1  completion error flag.
- `busy_o`  out  1  high whenever FSM is not IDLE.
- `axi_mosi_o`  out  `s_axi_mosi_t`  AXI manager outputs.
- `axi_miso_i`  in  `s_axi_miso_t`  AXI subordinate outputs.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: `req_ready_o`=1. On `req_valid_i`: capture addr/size/wdata/wstrb/we. Go to WR_REQ if `we`, else RD_REQ.
- WR_REQ: `awvalid` and `wvalid` assert together. Each deasserts independently on its own handshake. Track with `aw_done`/`w_done` flags. Go to WR_RESP once both handshakes are done, including the cycle where the last one occurs.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp`/`bid` and go to DONE.
- RD_REQ: `arvalid`=1. On `arready`, go to RD_RESP.
- RD_RESP: `rready`=1. On `rvalid`, capture `rdata`/`rresp`/`rid`/`rlast` and go to DONE.
- DONE: `resp_valid_o`=1 with stable data until `resp_ready_i`, then IDLE.
- `resp_err_o`=1 when any of these holds:
  - `bresp`/`rresp` is SLVERR or DECERR;
  - `bid`/`rid` ≠ `AXI_ID`;
  - read with `rlast`=0.
- OKAY and EXOKAY are not errors.
- Fixed AXI fields:
  - `awlen`/`arlen`=0, burst INCR, `wlast`=1 whenever `wvalid`=1.
  - `awsize`/`arsize` = captured size.
  - prot/cache/lock/qos/region/user all 0.
- Responses arriving outside the matching state are ignored: `bready`/`rready` are low there.
- Write data is never rotated or masked; read data is returned raw.

## Timing
- Reset (async assert, sync release). All outputs 0 in reset:
  - `req_ready_o`=0 while `rst`=0, then 1 from the first cycle after release (IDLE).
  - `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0, `busy_o`=0.
  - Every AXI valid/ready = 0.
- Reset mid-transaction: all valids drop immediately, FSM goes to IDLE, and the pending completion is discarded.
- All AXI valids and readys are registered. Once asserted, a valid stays high with stable payload until its handshake (AXI rule).
- Request accepted in cycle N → `awvalid`/`wvalid`/`arvalid` high in N+1.
- `resp_valid_o` rises the cycle after the B or R handshake.
- Against an always-ready subordinate with registered 1-cycle response:
  - accept N, AW/W handshake N+1, B handshake N+2, `resp_valid_o` N+3.
  - Same latency for reads.
- Throughput: one transaction in flight. Next accept is no earlier than the cycle after the `resp_valid_o`&`resp_ready_i` handshake.
- `busy_o` = (state ≠ IDLE), registered with the state.

## Test plan
- Write, always-ready subordinate: addr 0x100, wdata 0xDEADBEEF, wstrb 0xF, size word → AW/W handshakes in the same cycle, `awlen`=0, `wlast`=1, `resp_valid_o` 3 cycles after accept, `resp_err_o`=0, `resp_rdata_o`=0.
- Read-back of 0x100 → `arvalid` one cycle, `resp_rdata_o`=0xDEADBEEF, err=0. Byte read at 0x101 with wstrb-written data → raw lane data 0x0000BE00 when the subordinate masks.
- Skewed write handshakes: `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` held stable 4 cycles, `bready` only after both handshakes.
- Error paths:
  - `bresp`=SLVERR → `resp_err_o`=1.
  - `rid`=AXI_ID+1 with OKAY → err=1.
  - `rresp`=EXOKAY → err=0.
- Backpressure: `resp_ready_i` low 5 cycles → `resp_valid_o`/data held stable, `req_ready_o`=0 throughout, new request accepted the cycle after `resp_ready_i` rises.
- Reset asserted while `arvalid`=1 awaiting `arready` → `arvalid`, `busy_o` 0 immediately. After release, IDLE, no stale `resp_valid_o`, and a fresh read completes normally.
